// File: rtl/cfg_shift_loader.sv
// cfg_shift_loader: writer end of the configuration shift chain.
// Takes bitstream bytes over valid/ready, shifts them MSB-first into the chain
// head and assembles the bits leaving the chain tail into readback bytes.
module cfg_shift_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic       shift_clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       shift_en,
   output logic       shift_o,
   input  logic       shift_i,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

   state_t           r_state;
   logic [7:0]       r_tx_buf;
   logic [3:0]       r_bits_left;
   logic [CNT_W-1:0] r_bit_cnt;    // bits shifted into the chain
   logic [CNT_W-1:0] r_acc_cnt;    // bits accepted into the tx buffer
   logic [7:0]       r_rx;
   logic [2:0]       r_rx_cnt;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;
   logic             r_busy;
   logic             r_done;

   logic             w_load;
   logic             w_accept;
   logic             w_last_bit;
   logic             w_byte_full;
   logic [3:0]       w_take;
   logic [7:0]       w_rx_next;
   int               w_remain;

   // Handshake, chain enable and next-value helpers, all from registered state
   always_comb begin
      // NOTE: every always_comb output gets a value first so no path can infer a latch.
      w_load      = (r_state == ST_LOAD);
      shift_en    = w_load && (r_bits_left != 4'd0);
      shift_o     = r_tx_buf[7];
      // Refill while the last buffered bit is leaving, so bytes stream with no bubble.
      in_ready    = w_load
                    && ((r_bits_left == 4'd0) || ((r_bits_left == 4'd1) && shift_en))
                    && (r_acc_cnt < LEN);
      w_accept    = in_ready && in_valid;
      w_remain    = CHAIN_LEN - int'(r_acc_cnt);
      // A short final byte contributes only its upper bits.
      w_take      = (w_remain >= 8) ? 4'd8 : 4'(w_remain);
      w_rx_next   = {r_rx[6:0], shift_i};
      w_last_bit  = (r_bit_cnt == LAST_IDX);
      w_byte_full = (r_rx_cnt == 3'd7);
   end

   // FSM, tx buffer, bit counters and readback capture
   always_ff @(posedge shift_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_tx_buf    <= 8'h00;
         r_bits_left <= 4'd0;
         r_bit_cnt   <= '0;
         r_acc_cnt   <= '0;
         r_rx        <= 8'h00;
         r_rx_cnt    <= 3'd0;
         r_rd_data   <= 8'h00;
         r_rd_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state     <= ST_LOAD;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_tx_buf    <= 8'h00;
                  r_bits_left <= 4'd0;
                  r_bit_cnt   <= '0;
                  r_acc_cnt   <= '0;
                  r_rx        <= 8'h00;
                  r_rx_cnt    <= 3'd0;
               end
            end
            ST_LOAD: begin
               if (shift_en) begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  r_rx      <= w_rx_next;
                  r_rx_cnt  <= r_rx_cnt + 3'd1;
                  if (w_byte_full || w_last_bit) begin
                     // Left-align a partial final byte, zero-padding the low bits.
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= w_rx_next << (3'd7 - r_rx_cnt);
                     r_rx       <= 8'h00;
                     r_rx_cnt   <= 3'd0;
                  end
                  if (w_last_bit) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               if (w_accept) begin
                  r_tx_buf    <= in_data;
                  r_bits_left <= w_take;
                  r_acc_cnt   <= r_acc_cnt + CNT_W'(w_take);
               end else if (shift_en) begin
                  r_tx_buf    <= {r_tx_buf[6:0], 1'b0};
                  r_bits_left <= r_bits_left - 4'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_cfg_shift_loader.sv
// tb_cfg_shift_loader: two loaders (16-bit and 12-bit chains) driving behavioural
// shift chains. Expected readback and final chain contents are derived from the
// chain snapshot and byte stream; a monitor per loader pops the readback queue.
module tb_cfg_shift_loader;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       start0, start1;

   logic       rdy0, sen0, so0, rdv0, busy0, done0;
   logic       rdy1, sen1, so1, rdv1, busy1, done1;
   logic [7:0] rdd0, rdd1;

   logic [15:0] chain0;
   logic [11:0] chain1;
   logic        pre_req0 = 1'b0, pre_req1 = 1'b0;
   logic [15:0] pre_val0;
   logic [11:0] pre_val1;

   int cyc = 0;
   int n_shift0 = 0, n_shift1 = 0;
   int t_last0 = 0, t_last1 = 0;
   int run0 = 0, run1 = 0;
   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q_rd0[$];
   logic [7:0] q_rd1[$];

   cfg_shift_loader #(.CHAIN_LEN(16)) u_dut16 (
      .shift_clk(clk), .rst(rst), .start(start0), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .shift_en(sen0), .shift_o(so0), .shift_i(chain0[15]),
      .rd_data(rdd0), .rd_valid(rdv0), .busy(busy0), .done(done0)
   );

   cfg_shift_loader #(.CHAIN_LEN(12)) u_dut12 (
      .shift_clk(clk), .rst(rst), .start(start1), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .shift_en(sen1), .shift_o(so1), .shift_i(chain1[11]),
      .rd_data(rdd1), .rd_valid(rdv1), .busy(busy1), .done(done1)
   );

   // Behavioural chains plus shift bookkeeping (count, last shift cycle, run length)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_req0)            chain0 <= pre_val0;
      else if (sen0 === 1'b1)  chain0 <= {chain0[14:0], so0};
      if (pre_req1)            chain1 <= pre_val1;
      else if (sen1 === 1'b1)  chain1 <= {chain1[10:0], so1};
      if (sen0 === 1'b1) begin n_shift0 <= n_shift0 + 1; t_last0 <= cyc; run0 <= run0 + 1; end
      else run0 <= 0;
      if (sen1 === 1'b1) begin n_shift1 <= n_shift1 + 1; t_last1 <= cyc; run1 <= run1 + 1; end
      else run1 <= 0;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Readback monitor for the 16-bit loader
   always @(negedge clk) begin
      if (rdv0 === 1'b1) begin
         if (q_rd0.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd16_unexpected got rd_data=0x%0h exp=no pending byte", rdd0);
         end else check("rd16_data", 32'(rdd0), 32'(q_rd0.pop_front()));
      end
   end

   // Readback monitor for the 12-bit loader
   always @(negedge clk) begin
      if (rdv1 === 1'b1) begin
         if (q_rd1.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd12_unexpected got rd_data=0x%0h exp=no pending byte", rdd1);
         end else check("rd12_data", 32'(rdd1), 32'(q_rd1.pop_front()));
      end
   end

   function automatic logic [15:0] get_chain(input int s);
      return (s != 0) ? {4'h0, chain1} : chain0;
   endfunction
   function automatic logic get_rdy(input int s);  return (s != 0) ? rdy1  : rdy0;  endfunction
   function automatic logic get_sen(input int s);  return (s != 0) ? sen1  : sen0;  endfunction
   function automatic logic get_busy(input int s); return (s != 0) ? busy1 : busy0; endfunction
   function automatic logic get_done(input int s); return (s != 0) ? done1 : done0; endfunction
   function automatic int   get_nsh(input int s);  return (s != 0) ? n_shift1 : n_shift0; endfunction

   task automatic drive_start(input int s, input logic v);
      if (s != 0) start1 = v; else start0 = v;
   endtask

   task automatic preload(input int s, input logic [15:0] v);
      if (s != 0) begin pre_val1 = v[11:0]; pre_req1 = 1'b1; end
      else        begin pre_val0 = v;       pre_req0 = 1'b1; end
      @(negedge clk);
      pre_req0 = 1'b0; pre_req1 = 1'b0;
   endtask

   // Returns at a falling edge where in_ready is high (bounded)
   task automatic wait_ready(input int s);
      int w = 0;
      while (get_rdy(s) !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      check("in_ready_seen", 32'(get_rdy(s)), 32'd1);
   endtask

   task automatic pulse_start(input int s);
      drive_start(s, 1'b1);
      @(negedge clk);
      drive_start(s, 1'b0);
   endtask

   // One full load of two bytes; gap = idle in_valid cycles between the bytes
   task automatic run_load(input int s, input logic [7:0] b0, input logic [7:0] b1,
                           input int gap, input bit mid_start);
      int L = (s != 0) ? 12 : 16;
      logic [15:0] c0 = get_chain(s);
      logic [15:0] expc = '0;
      logic [15:0] snap;
      logic [7:0]  bs[2];
      int sh0, w;
      bs[0] = b0; bs[1] = b1;
      // Readback = current chain contents, tail bit first, in zero-padded bytes
      for (int b = 0; b * 8 < L; b++) begin
         logic [7:0] v = 8'h00;
         for (int k = 0; k < 8; k++)
            if (b * 8 + k < L) v[7-k] = c0[L-1-(b*8+k)];
         if (s != 0) q_rd1.push_back(v); else q_rd0.push_back(v);
      end
      // Final chain = first L bits of the stream, first bit deepest
      for (int j = 0; j < L; j++) expc[L-1-j] = bs[j/8][7-(j%8)];
      sh0 = get_nsh(s);

      pulse_start(s);
      check("busy_after_start", 32'(get_busy(s)), 32'd1);
      check("done_after_start", 32'(get_done(s)), 32'd0);

      in_data = bs[0]; in_valid = 1'b1;
      wait_ready(s);
      @(negedge clk);
      in_data = bs[1];
      if (gap > 0) in_valid = 1'b0;
      if (mid_start) pulse_start(s);
      if (gap > 0) begin
         wait_ready(s);
         @(negedge clk);
         snap = get_chain(s);
         for (int k = 0; k < gap; k++) begin
            check("stall_shift_en", 32'(get_sen(s)), 32'd0);
            check("stall_chain", 32'(get_chain(s)), 32'(snap));
            @(negedge clk);
         end
         in_valid = 1'b1;
      end
      wait_ready(s);
      @(negedge clk);
      in_valid = 1'b0;
      check("ready_low_after_last_byte", 32'(get_rdy(s)), 32'd0);

      w = 0;
      while (get_done(s) !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      check("done_seen", 32'(get_done(s)), 32'd1);
      check("done_latency", 32'(cyc - ((s != 0) ? t_last1 : t_last0)), 32'd1);
      check("shift_count", 32'(get_nsh(s) - sh0), 32'(L));
      check("chain_final", 32'(get_chain(s)), 32'(expc));
      check("busy_in_done", 32'(get_busy(s)), 32'd0);
      check("ready_in_done", 32'(get_rdy(s)), 32'd0);
      if (gap == 0) check("consecutive_shifts", 32'((s != 0) ? run1 : run0), 32'(L));
      @(negedge clk);
      check("readback_drained", 32'((s != 0) ? q_rd1.size() : q_rd0.size()), 32'd0);
      check("done_holds", 32'(get_done(s)), 32'd1);
   endtask

   initial begin
      int sh0, w;
      // Reset with start and in_valid asserted
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; start0 = 1'b1; start1 = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; start0 = 1'b0; start1 = 1'b0;
      check("rst_outputs16", {22'd0, rdy0, sen0, so0, rdv0, busy0, done0, 2'b00}, 32'd0);
      check("rst_rd_data16", 32'(rdd0), 32'd0);
      check("rst_outputs12", {22'd0, rdy1, sen1, so1, rdv1, busy1, done1, 2'b00}, 32'd0);
      check("rst_rd_data12", 32'(rdd1), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("idle_no_shift", 32'(sen0 | sen1), 32'd0);
      end

      // Directed: clean load, stalled load, partial final byte
      preload(0, 16'h1234);
      run_load(0, 8'hA5, 8'h3C, 0, 1'b0);
      preload(0, 16'h1234);
      run_load(0, 8'hA5, 8'h3C, 3, 1'b0);
      preload(1, 16'h0FFF);
      run_load(1, 8'hF0, 8'hAB, 0, 1'b0);

      // Reset after 5 shifts, then a clean load from scratch
      preload(0, 16'($urandom));
      sh0 = n_shift0;
      pulse_start(0);
      in_data = 8'($urandom); in_valid = 1'b1;
      wait_ready(0);
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (n_shift0 - sh0 < 5 && w < 50) begin @(negedge clk); w++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_shift_en", 32'(sen0), 32'd0);
      check("abort_busy", 32'(busy0), 32'd0);
      check("abort_done", 32'(done0), 32'd0);
      run_load(0, 8'h5A, 8'hC3, 0, 1'b0);

      // start during LOAD ignored; start from DONE relaunches
      run_load(0, 8'h81, 8'h7E, 0, 1'b1);
      run_load(1, 8'h0F, 8'h96, 0, 1'b1);

      // Randomised loads on both chains
      for (int r = 0; r < 8; r++) begin
         int s = int'($urandom_range(0, 1));
         preload(s, 16'($urandom));
         run_load(s, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cfg_shift_loader.md
Name: cfg_shift_loader

Overview:
- Drives the configuration shift chain formed by the CLB and interconnect shift_i/shift_o daisy-chain. It is the writer end of that chain.
- Accepts a configuration bitstream as bytes over a valid/ready handshake and serialises it MSB-first onto the chain head.
- Gates shift_en so the chain advances only when a bit is available.
- Captures the bits that fall out of the chain tail and returns them as readback bytes.

Parameters:
- CHAIN_LEN, 64, total number of configuration bits in the chain; any value >= 1 and need not be a multiple of 8.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- shift_clk  input  1  single clock for the loader and the chain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_data  input  8  configuration byte, MSB shifted first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- shift_en  output  1  chain shift enable.
- shift_o  output  1  serial bit to the chain head (shift_i of the first element).
- shift_i  input  1  serial bit from the chain tail (shift_o of the last element).
- rd_data  output  8  readback byte, first-exiting bit in the MSB.
- rd_valid  output  1  one-cycle pulse; rd_data is valid; no backpressure.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.

Behaviour:
- Clocking: all state changes on the rising edge of shift_clk; rst is sampled synchronously.
- Reset values, effective the cycle after rst is sampled high: state IDLE; in_ready, shift_en, shift_o, rd_valid, busy, done all 0; rd_data 8'h00; bit counter, tx buffer and rx assembly register cleared.
- Reset mid-LOAD aborts the load. Chain contents are left as-is (partially shifted).
- States:
  - IDLE -> LOAD on start; clears the bit counter.
  - LOAD -> DONE on the edge that shifts bit CHAIN_LEN-1 (the last bit).
  - DONE -> LOAD on start; DONE holds otherwise.
  - start in LOAD is ignored.
- tx buffer: holds up to 8 bits plus bits_left (0..8).
- in_ready = (state==LOAD) && (bits_left==0 || (bits_left==1 && shift_en)) && (bits_sent_or_buffered < CHAIN_LEN).
  - This keeps throughput at 1 bit/cycle with no bubble between bytes.
- Byte acceptance: on accept, bits_left loads min(8, CHAIN_LEN - bits already accepted).
  - A short final byte uses its upper bits only; the lower bits are discarded.
- shift_en = (state==LOAD) && bits_left>0; shift_o = buffer MSB. Both are combinational from registered state.
  - When no data is buffered, shift_en is 0 and the chain holds.
- Each edge with shift_en=1:
  - buffer shifts left; bits_left decrements; bit counter increments;
  - shift_i is sampled into the rx register (this is the bit leaving the chain on that edge).
- Readback: rd_valid pulses for one cycle after the edge that samples the 8th rx bit, or the final bit of the chain.
  - A final partial byte is left-aligned and zero-padded in the low bits.
  - rd_data holds its value until the next rd_valid.
- in_valid outside LOAD is ignored; in_ready is 0 there.
- done rises on the cycle after the last shift and stays high until start or rst.
- Latency: first shift_en occurs the cycle after the first accepted byte. A full load with no stalls takes CHAIN_LEN shift cycles plus 1.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 and start=1 -> after release all outputs are 0, state is IDLE, and no shift_en pulses occur.
- CHAIN_LEN=16, chain model preloaded 16'h1234; start, then bytes 8'hA5, 8'h3C with in_valid held high:
  - shift_en is high for exactly 16 consecutive cycles; chain ends at 16'hA53C;
  - rd_valid pulses twice with 8'h12 then 8'h34; done=1 one cycle after the last shift.
- Stall: same load with in_valid dropped for 3 cycles between bytes -> shift_en is low for those 3 cycles, chain contents unchanged during the gap, final result identical.
- Partial byte, CHAIN_LEN=12, chain preloaded 12'hFFF; bytes 8'hF0, 8'hAB:
  - exactly 12 shifts; chain becomes 12'hF0A;
  - in_ready stays low after the second byte;
  - readback is 8'hFF then 8'hF0 (zero-padded).
- Reset mid-load: assert rst after 5 shifts -> shift_en is 0 from the next cycle, busy=0, done=0; a following start with a full byte stream completes a correct load from bit 0.
- Start handling: start pulsed during LOAD -> ignored, counter not cleared; start in DONE -> done falls, busy rises, and a second full load completes.
